// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator TRNG post-processing chain.
package trng_pkg;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_HAVE_FIRST = 1'b1
  } pair_state_e;

  localparam int TRNG_WORD_W    = 8;
  localparam int TRNG_REP_LIMIT = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/trng_vn_extractor.sv
// Von Neumann pair extractor: emits one debiased bit per unequal raw-bit pair.
module trng_vn_extractor
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sample_en,
  input  logic raw_bit,
  output logic bit_valid,
  output logic bit_out
);

  pair_state_e state_q, state_d;
  logic        first_q, first_d;

  // bit_valid is combinational so a word can complete on the edge that registers its last raw bit
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    bit_valid = 1'b0;
    bit_out   = first_q;
    if (!ena) begin
      state_d = ST_IDLE;
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          first_d = raw_bit;
          state_d = ST_HAVE_FIRST;
        end
        ST_HAVE_FIRST: begin
          state_d   = ST_IDLE;
          bit_valid = (raw_bit != first_q);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/trng_vn_packer.sv
// Debiases the synchronised raw TRNG stream and packs it into WIDTH-bit valid/ready words.
// Define TRNG_HEALTH_EN to add the sticky repetition-count health test.
module trng_vn_packer
  import trng_pkg::*;
#(
  parameter int WIDTH     = TRNG_WORD_W,
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             raw_bit,
  input  logic             sample_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             health_fail
);

  localparam int             CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic             bit_valid;
  logic             bit_out;
  logic             words_blocked;

  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;

  trng_vn_extractor u_extractor (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sample_en (sample_en),
    .raw_bit   (raw_bit),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  // The final bit of a word bypasses shift so the holding register loads on the completing edge
  always_comb begin
    shift_d     = shift_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bit_valid) begin
      if (count_q != LAST_IDX) begin
        shift_d[count_q] = bit_out;
        count_d          = count_q + 1'b1;
      end else if (words_blocked) begin
        count_d = '0;
      end else if (!out_valid_q || out_ready) begin
        out_data_d  = {bit_out, shift_q};
        out_valid_d = 1'b1;
        count_d     = '0;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int               RUN_W   = clog2(REP_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REP_LIMIT);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             health_fail_q, health_fail_d;

  // run_q == 0 only before the first sample, so it doubles as the "no previous bit" flag
  always_comb begin
    run_d         = run_q;
    last_d        = last_q;
    health_fail_d = health_fail_q;
    if (ena && sample_en) begin
      last_d = raw_bit;
      if (run_q == '0 || raw_bit != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
      if (run_d == RUN_MAX) begin
        health_fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q         <= '0;
      last_q        <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      last_q        <= last_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign words_blocked = health_fail_q;
  assign health_fail   = health_fail_q;
`else
  assign words_blocked = 1'b0;
  assign health_fail   = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule
